// File: rtl/spi_load_scheduler_if.sv
// Request, buffer-strobe and loader-control signals of the SPI load scheduler.
// The requester/loader side uses master; the scheduler uses slave.
interface spi_load_scheduler_if;
  logic [2:0]  IMGSEL;
  logic        BOOTREQ;
  logic        PAGEREQ;
  logic [11:0] PAGEPOS;
  logic        BUFWCLK;
  logic [2:0]  IMGNUM;
  logic [2:0]  ACCTYPE;
  logic [11:0] ABSPOS;
  logic        BUSY;
  logic        BOOTDONE;
  logic        PAGEDONE;
  logic        ERR;

  modport master (
    output IMGSEL, BOOTREQ, PAGEREQ, PAGEPOS, BUFWCLK,
    input  IMGNUM, ACCTYPE, ABSPOS, BUSY, BOOTDONE, PAGEDONE, ERR
  );

  modport slave (
    input  IMGSEL, BOOTREQ, PAGEREQ, PAGEPOS, BUFWCLK,
    output IMGNUM, ACCTYPE, ABSPOS, BUSY, BOOTDONE, PAGEDONE, ERR
  );
endinterface

// File: rtl/spi_load_scheduler.sv
// Arbitrates boot/page load requests, drives the SPI flash loader and detects
// completion by counting synchronised buffer write strobes.
module spi_load_scheduler #(
  parameter logic [15:0] BOOT_BITS   = 16'd4096,
  parameter logic [15:0] PAGE_BITS   = 16'd584,
  parameter logic [11:0] POS_MAX     = 12'd2052,
  parameter logic [7:0]  IDLE_GAP    = 8'd4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1000000
) (
  input  logic                 MCLK,
  input  logic                 RESET,
  spi_load_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SYNC, BOOT_RUN, PAGE_RUN, GAP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  bufw_q, bufw_d;
  logic [15:0] edge_cnt_q, edge_cnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic [7:0]  gap_q, gap_d;
  logic [2:0]  imgnum_q, imgnum_d;
  logic [11:0] abspos_q, abspos_d;
  logic [2:0]  acctype_q, acctype_d;
  logic        busy_q, busy_d;
  logic        bootdone_q, bootdone_d;
  logic        pagedone_q, pagedone_d;
  logic        err_q, err_d;
  logic        bufw_edge;
  logic [15:0] run_bits;

  // bufw_q[1:0] is the synchroniser, bufw_q[2] the edge-detect delay
  assign bufw_d    = {bufw_q[1:0], bus.BUFWCLK};
  assign bufw_edge = bufw_q[1] & ~bufw_q[2];
  assign run_bits  = (state_q == BOOT_RUN) ? BOOT_BITS : PAGE_BITS;

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    imgnum_d   = imgnum_q;
    abspos_d   = abspos_q;
    bootdone_d = 1'b0;
    pagedone_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        tmo_d      = '0;
        gap_d      = '0;
        if (bus.BOOTREQ) begin
          imgnum_d = bus.IMGSEL;
          abspos_d = '0;
          state_d  = BOOT_RUN;
        end else if (bus.PAGEREQ) begin
          if (bus.PAGEPOS <= POS_MAX) begin
            imgnum_d = bus.IMGSEL;
            abspos_d = bus.PAGEPOS;
            state_d  = SYNC;
          end else begin
            err_d   = 1'b1;
            state_d = GAP;
          end
        end
      end
      SYNC: state_d = PAGE_RUN;
      BOOT_RUN, PAGE_RUN: begin
        if (bufw_edge && edge_cnt_q != 16'hFFFF) edge_cnt_d = edge_cnt_q + 16'd1;
        if (tmo_q != 24'hFFFFFF) tmo_d = tmo_q + 24'd1;
        // Completion is tested first so an edge on the timeout cycle wins
        if (bufw_edge && edge_cnt_d == run_bits) begin
          bootdone_d = (state_q == BOOT_RUN);
          pagedone_d = (state_q == PAGE_RUN);
          state_d    = GAP;
        end else if (tmo_d == TIMEOUT_CYC) begin
          err_d   = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q + 8'd1 >= IDLE_GAP) state_d = IDLE;
        else gap_d = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      SYNC:     acctype_d = 3'b001;
      BOOT_RUN: acctype_d = 3'b110;
      PAGE_RUN: acctype_d = 3'b111;
      default:  acctype_d = 3'b000;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      bufw_q     <= '0;
      edge_cnt_q <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      imgnum_q   <= '0;
      abspos_q   <= '0;
      acctype_q  <= '0;
      busy_q     <= 1'b0;
      bootdone_q <= 1'b0;
      pagedone_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bufw_q     <= bufw_d;
      edge_cnt_q <= edge_cnt_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      imgnum_q   <= imgnum_d;
      abspos_q   <= abspos_d;
      acctype_q  <= acctype_d;
      busy_q     <= busy_d;
      bootdone_q <= bootdone_d;
      pagedone_q <= pagedone_d;
      err_q      <= err_d;
    end
  end

  assign bus.IMGNUM   = imgnum_q;
  assign bus.ACCTYPE  = acctype_q;
  assign bus.ABSPOS   = abspos_q;
  assign bus.BUSY     = busy_q;
  assign bus.BOOTDONE = bootdone_q;
  assign bus.PAGEDONE = pagedone_q;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_spi_load_scheduler.sv
// Scoreboard bench for spi_load_scheduler: stimulus queues the expected output
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_spi_load_scheduler;
  localparam int TO = 20000;

  logic MCLK  = 1'b0;
  logic RESET = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  spi_load_scheduler_if bus ();

  spi_load_scheduler #(.TIMEOUT_CYC(24'd20000)) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  acc;
    logic [2:0]  img;
    logic [11:0] pos;
    logic        busy;
    logic        bd;
    logic        pd;
    logic        er;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  bit         mon_en = 0;
  logic [2:0] prev_acc;
  logic       prev_busy;

  task automatic expectEv(input int c, input logic [2:0] acc, input logic [2:0] img,
                          input logic [11:0] pos, input logic busy, input logic bd,
                          input logic pd, input logic er);
    ev_t e;
    e.cyc = c; e.acc = acc; e.img = img; e.pos = pos;
    e.busy = busy; e.bd = bd; e.pd = pd; e.er = er;
    exp_q.push_back(e);
  endtask

  // An output event is any ACCTYPE/BUSY change or any asserted pulse
  always @(negedge MCLK) begin
    if (mon_en) begin
      if (bus.ACCTYPE !== prev_acc || bus.BUSY !== prev_busy ||
          bus.BOOTDONE !== 1'b0 || bus.PAGEDONE !== 1'b0 || bus.ERR !== 1'b0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_event cyc=%0d acc=%b img=%0d pos=%0d busy=%b bd=%b pd=%b err=%b (no event required)",
                   cyc, bus.ACCTYPE, bus.IMGNUM, bus.ABSPOS, bus.BUSY, bus.BOOTDONE, bus.PAGEDONE, bus.ERR);
        end else begin
          mon_e = exp_q.pop_front();
          if (cyc != mon_e.cyc || bus.ACCTYPE !== mon_e.acc || bus.IMGNUM !== mon_e.img ||
              bus.ABSPOS !== mon_e.pos || bus.BUSY !== mon_e.busy || bus.BOOTDONE !== mon_e.bd ||
              bus.PAGEDONE !== mon_e.pd || bus.ERR !== mon_e.er) begin
            bad++;
            $display("[TB] FAIL event got cyc=%0d acc=%b img=%0d pos=%0d busy=%b bd=%b pd=%b err=%b want cyc=%0d acc=%b img=%0d pos=%0d busy=%b bd=%b pd=%b err=%b",
                     cyc, bus.ACCTYPE, bus.IMGNUM, bus.ABSPOS, bus.BUSY, bus.BOOTDONE, bus.PAGEDONE, bus.ERR,
                     mon_e.cyc, mon_e.acc, mon_e.img, mon_e.pos, mon_e.busy, mon_e.bd, mon_e.pd, mon_e.er);
          end
        end
      end
      prev_acc  = bus.ACCTYPE;
      prev_busy = bus.BUSY;
    end
  end

  task automatic tick;
    @(posedge MCLK);
    #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) tick();
  endtask

  task automatic applyStimulus(input logic boot, input logic page,
                               input logic [2:0] img, input logic [11:0] pos);
    bus.BOOTREQ = boot;
    bus.PAGEREQ = page;
    bus.IMGSEL  = img;
    bus.PAGEPOS = pos;
  endtask

  // Rising edges at the start cycle and every 4 cycles after it
  task automatic sendPulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.BUFWCLK = 1'b1;
      tick(); tick();
      bus.BUFWCLK = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic checkOutput(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s, l, l2, x;
    applyStimulus(1'b0, 1'b0, 3'd0, 12'd0);
    bus.BUFWCLK = 1'b0;
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    checkOutput("reset_acctype",  {9'd0, bus.ACCTYPE},  12'd0);
    checkOutput("reset_busy",     {11'd0, bus.BUSY},    12'd0);
    checkOutput("reset_imgnum",   {9'd0, bus.IMGNUM},   12'd0);
    checkOutput("reset_abspos",   bus.ABSPOS,           12'd0);
    checkOutput("reset_bootdone", {11'd0, bus.BOOTDONE}, 12'd0);
    checkOutput("reset_pagedone", {11'd0, bus.PAGEDONE}, 12'd0);
    checkOutput("reset_err",      {11'd0, bus.ERR},     12'd0);
    prev_acc  = bus.ACCTYPE;
    prev_busy = bus.BUSY;
    mon_en    = 1;
    repeat (100) tick();

    $display("[TB] boot load");
    t = cyc;
    applyStimulus(1'b1, 1'b0, 3'd3, 12'd0);
    expectEv(t + 1, 3'b110, 3'd3, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd3, 12'd0);
    tick();
    s = cyc;
    l = s + 4 * 4095;
    expectEv(l + 3, 3'b000, 3'd3, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEv(l + 7, 3'b000, 3'd3, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPulses(4096);
    waitUntil(l + 10);

    $display("[TB] page load");
    t = cyc;
    applyStimulus(1'b0, 1'b1, 3'd5, 12'd1018);
    expectEv(t + 1, 3'b001, 3'd5, 12'd1018, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEv(t + 2, 3'b111, 3'd5, 12'd1018, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    applyStimulus(1'b0, 1'b0, 3'd2, 12'd5);
    tick();
    s = cyc;
    l = s + 4 * 583;
    expectEv(l + 3, 3'b000, 3'd5, 12'd1018, 1'b1, 1'b0, 1'b1, 1'b0);
    expectEv(l + 7, 3'b000, 3'd5, 12'd1018, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPulses(584);
    waitUntil(l + 10);

    $display("[TB] simultaneous requests");
    t = cyc;
    applyStimulus(1'b1, 1'b1, 3'd1, 12'd100);
    expectEv(t + 1, 3'b110, 3'd1, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 3'd1, 12'd100);
    tick();
    s = cyc;
    l = s + 4 * 4095;
    expectEv(l + 3, 3'b000, 3'd1, 12'd0,   1'b1, 1'b1, 1'b0, 1'b0);
    expectEv(l + 7, 3'b000, 3'd1, 12'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    expectEv(l + 8, 3'b001, 3'd1, 12'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEv(l + 9, 3'b111, 3'd1, 12'd100, 1'b1, 1'b0, 1'b0, 1'b0);
    sendPulses(4096);
    waitUntil(l + 9);
    applyStimulus(1'b0, 1'b0, 3'd1, 12'd100);
    tick();
    s = cyc;
    l2 = s + 4 * 583;
    expectEv(l2 + 3, 3'b000, 3'd1, 12'd100, 1'b1, 1'b0, 1'b1, 1'b0);
    expectEv(l2 + 7, 3'b000, 3'd1, 12'd100, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPulses(584);
    waitUntil(l2 + 10);

    $display("[TB] illegal position");
    t = cyc;
    applyStimulus(1'b0, 1'b1, 3'd6, 12'd2053);
    expectEv(t + 1, 3'b000, 3'd1, 12'd100, 1'b1, 1'b0, 1'b0, 1'b1);
    expectEv(t + 5, 3'b000, 3'd1, 12'd100, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd6, 12'd2053);
    waitUntil(t + 8);

    $display("[TB] timeout at highest legal position");
    t = cyc;
    applyStimulus(1'b0, 1'b1, 3'd7, 12'd2052);
    expectEv(t + 1,      3'b001, 3'd7, 12'd2052, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEv(t + 2,      3'b111, 3'd7, 12'd2052, 1'b1, 1'b0, 1'b0, 1'b0);
    expectEv(t + 2 + TO, 3'b000, 3'd7, 12'd2052, 1'b1, 1'b0, 1'b0, 1'b1);
    expectEv(t + 6 + TO, 3'b000, 3'd7, 12'd2052, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    applyStimulus(1'b0, 1'b0, 3'd7, 12'd2052);
    waitUntil(t + TO + 10);

    $display("[TB] reset mid-access");
    t = cyc;
    applyStimulus(1'b1, 1'b0, 3'd4, 12'd0);
    expectEv(t + 1, 3'b110, 3'd4, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd4, 12'd0);
    tick();
    sendPulses(100);
    x = cyc;
    RESET = 1'b1;
    expectEv(x + 1, 3'b000, 3'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    RESET = 1'b0;
    tick();
    t = cyc;
    applyStimulus(1'b1, 1'b0, 3'd4, 12'd0);
    expectEv(t + 1, 3'b110, 3'd4, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd4, 12'd0);
    tick();
    s = cyc;
    l = s + 4 * 4095;
    expectEv(l + 3, 3'b000, 3'd4, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    expectEv(l + 7, 3'b000, 3'd4, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPulses(4096);
    waitUntil(l + 10);

    repeat (5) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL pending_events left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
